mult_exhaustive_evaluator: RTL
==============================

# mult_exhaustive_evaluator

Sequential evaluation stage that sits around a candidate combinational 2-operand multiplier: it drives every operand pair onto the candidate's `A`/`B` inputs, consumes the candidate's product `P`, and compares it against a golden `A*B`. The result is a correct-vector count, which is the reward the RL search loop reads back for each generated multiplier architecture. It is also an error count, with an optional first-failure record. One evaluation sweeps all 2^(2·WIDTH) input combinations.

## Interface
- `WIDTH`, default 2: operand width. Legal values are 2..4. Product width is 2·WIDTH.
- `clk`  in  1  the single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a sweep. Accepted only in IDLE or DONE.
- `a_out`  out  WIDTH  operand A driven to the candidate.
- `b_out`  out  WIDTH  operand B driven to the candidate.
- `p_in`  in  2·WIDTH  product returned by the candidate, combinational from `a_out`/`b_out`.
- `busy`  out  1  high while the sweep runs.
- `done`  out  1  high from the end of a sweep until the next `start` or reset.
- `correct_count`  out  2·WIDTH+1  number of vectors where `p_in` equals the golden product.
- `error_count`  out  2·WIDTH+1  number of mismatching vectors.
- `perfect`  out  1  high when `done` is set and `error_count` is 0.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **Reset values.** Reset forces state IDLE and the vector index to 0. It drives `a_out`, `b_out`, both counts, `busy`, `done` and `perfect` to 0. All first-error outputs also reset to 0.
- **IDLE → RUN** on `start`:
  - index cleared to 0;
  - both counts cleared;
  - first-error record cleared.
- **RUN, every cycle:**
  - `{a_out, b_out}` = index, with A in the high bits. Vector order is therefore A=0,B=0; A=0,B=1; …; A=max,B=max.
  - `p_in` is compared against `a_out*b_out`, computed unsigned at 2·WIDTH bits.
  - On a match, `correct_count` increments. On a mismatch, `error_count` increments.
  - The index then increments.
- **RUN → DONE:** after the compare at index 2^(2·WIDTH)−1. The index does not wrap back into a second sweep.
- **DONE:**
  - counts are held;
  - `a_out`/`b_out` hold the last vector;
  - `start` restarts the sweep exactly as it does from IDLE.
- **`start` during RUN:** ignored.
- **Reset mid-sweep:** returns immediately to IDLE with everything cleared. No partial results are retained.
- **Count invariant:** in DONE, `correct_count + error_count` = 2^(2·WIDTH). The counts cannot overflow, because their width is 2·WIDTH+1.

## Timing
- `start` is sampled at edge 0. `busy` goes high and vector 0 appears on `a_out`/`b_out` after edge 0.
- Vector k is presented in the cycle after edge k and compared at edge k+1.
- `busy` falls and `done` rises after edge N, where N = 2^(2·WIDTH). For WIDTH=2 this is edge 16.
- `correct_count`/`error_count` are final in the same cycle that `done` rises.
- The `p_in` path from `a_out`/`b_out` through the candidate must close within one clock. The block adds no pipeline stage on `p_in`.

## Configuration
- Macro: `EVAL_FIRST_ERR_EN`.
- **Defined:** three extra outputs are present:
  - `first_err_valid` (1);
  - `first_err_a` (WIDTH);
  - `first_err_b` (WIDTH).
- The record latches the operands of the first mismatching vector in a sweep. Later mismatches do not change it. The record clears on `start` and on reset.
- **Not defined:** these ports and their registers are absent. Counting behaviour is identical in both cases.

## Structure
- Shared package `mult_eval_pkg`:
  - state enum `eval_state_t` (IDLE, RUN, DONE);
  - function `n_vectors(width)` returning 2^(2·width);
  - constant `MAX_WIDTH` = 4.
- Sub-module `mult_eval_golden`: parameterised combinational golden multiplier with a registered-compare-free interface. Its inputs are a and b; its outputs are the product and a match flag against `p_in`.
- The FSM, counters and first-error logic stay in the top module.

## Test plan
- **Ideal candidate, WIDTH=2:** `p_in` = a·b, one `start` → `done` after 16 cycles; `correct_count`=16, `error_count`=0, `perfect`=1.
- **`p_in[0]` stuck at 0:**
  - `correct_count`=12, `error_count`=4, `perfect`=0.
  - With `EVAL_FIRST_ERR_EN`: first error is A=1, B=1.
- **`p_in` forced to 0:** `correct_count`=7 (every vector with A=0 or B=0), `error_count`=9.
- **Reset at cycle 8 of a sweep:** all outputs return to 0 asynchronously. A new `start` then gives full, correct results.
- **`start` pulsed again at cycle 5 of RUN:** ignored, and `done` still occurs at cycle 16. A `start` while in DONE clears the counts and reruns the sweep with identical results.
- **WIDTH=3, ideal candidate:** 64 vectors; `correct_count`=64 with a 7-bit count; `done` after edge 64.

Source files
------------

// File: rtl/mult_eval_pkg.sv
// Shared types and helpers for the exhaustive multiplier evaluator.
package mult_eval_pkg;

    localparam int MAX_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } eval_state_t;

    function automatic int n_vectors(input int width);
        return 1 << (2 * width);
    endfunction

endpackage

// File: rtl/mult_exhaustive_evaluator_if.sv
// Bus between the evaluator and its host/candidate.
// EVAL_FIRST_ERR_EN adds the first-failure record signals.
interface mult_exhaustive_evaluator_if #(parameter int WIDTH = 2) ();

    logic                 start;
    logic [WIDTH-1:0]     a_out;
    logic [WIDTH-1:0]     b_out;
    logic [2*WIDTH-1:0]   p_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH:0]     correct_count;
    logic [2*WIDTH:0]     error_count;
    logic                 perfect;
`ifdef EVAL_FIRST_ERR_EN
    logic                 first_err_valid;
    logic [WIDTH-1:0]     first_err_a;
    logic [WIDTH-1:0]     first_err_b;
`endif

`ifdef EVAL_FIRST_ERR_EN
    modport master (
        output start, p_in,
        input  a_out, b_out, busy, done, correct_count, error_count, perfect,
               first_err_valid, first_err_a, first_err_b
    );
    modport slave (
        input  start, p_in,
        output a_out, b_out, busy, done, correct_count, error_count, perfect,
               first_err_valid, first_err_a, first_err_b
    );
`else
    modport master (
        output start, p_in,
        input  a_out, b_out, busy, done, correct_count, error_count, perfect
    );
    modport slave (
        input  start, p_in,
        output a_out, b_out, busy, done, correct_count, error_count, perfect
    );
`endif

endinterface

// File: rtl/mult_eval_golden.sv
// Combinational golden multiplier and match flag against the candidate product.
module mult_eval_golden #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] p_in,
    output logic [2*WIDTH-1:0] product,
    output logic               match
);

    assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign match   = (p_in == product);

endmodule

// File: rtl/mult_exhaustive_evaluator.sv
// Sweeps every operand pair into a candidate multiplier and counts correct/wrong products.
// Optional first-failure record enabled by EVAL_FIRST_ERR_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | presenting vector idx, comparing p_in each cycle
// DONE  | sweep complete, results held until start or reset
module mult_exhaustive_evaluator
    import mult_eval_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    mult_exhaustive_evaluator_if.slave    bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(n_vectors(WIDTH) - 1);

    eval_state_t   state;
    logic [PW-1:0] idx;
    logic [CW-1:0] correct_q;
    logic [CW-1:0] error_q;
    logic          busy_q;
    logic          done_q;
    logic          perfect_q;
    logic [PW-1:0] golden_product;
    logic          match;
    logic          unused_product_bits;

    mult_eval_golden #(.WIDTH(WIDTH)) u_golden (
        .a       (idx[PW-1:WIDTH]),
        .b       (idx[WIDTH-1:0]),
        .p_in    (bus.p_in),
        .product (golden_product),
        .match   (match)
    );

    assign unused_product_bits = ^golden_product;

`ifdef EVAL_FIRST_ERR_EN
    logic             fe_valid;
    logic [WIDTH-1:0] fe_a;
    logic [WIDTH-1:0] fe_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_valid <= 1'b0;
            fe_a     <= '0;
            fe_b     <= '0;
        end else if (state != RUN && bus.start) begin
            fe_valid <= 1'b0;
            fe_a     <= '0;
            fe_b     <= '0;
        end else if (state == RUN && !match && !fe_valid) begin
            fe_valid <= 1'b1;
            fe_a     <= idx[PW-1:WIDTH];
            fe_b     <= idx[WIDTH-1:0];
        end
    end

    assign bus.first_err_valid = fe_valid;
    assign bus.first_err_a     = fe_a;
    assign bus.first_err_b     = fe_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            correct_q <= '0;
            error_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            perfect_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        idx       <= '0;
                        correct_q <= '0;
                        error_q   <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        perfect_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (match) correct_q <= correct_q + 1'b1;
                    else       error_q   <= error_q + 1'b1;
                    // Stop on the last vector so a/b hold it in DONE.
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        perfect_q <= match && (error_q == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out         = idx[PW-1:WIDTH];
    assign bus.b_out         = idx[WIDTH-1:0];
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.correct_count = correct_q;
    assign bus.error_count   = error_q;
    assign bus.perfect       = perfect_q;

endmodule
